add_order_parser: RTL and testbench
===================================

// Module: add_order_parser
// PURPOSE
//  Byte-stream decoder upstream of the book-entry packing stage.
//  - Input: framed feed messages, one byte per cycle.
//  - Recognises Add Order messages and extracts order_id, side, quantity and price.
//  - Presents the fields as registered outputs with a one-cycle add_valid strobe.
//  - Every other message type is skipped to end-of-message.
// PARAMETERS
//  ADD_TYPE   8'h41  message-type byte for Add Order ('A')
//  BUY_CHAR   8'h42  side byte meaning buy ('B')
//  SELL_CHAR  8'h53  side byte meaning sell ('S')
// PORTS
//  clk               in   1   clock, all logic on rising edge
//  rst_n             in   1   asynchronous active-low reset
//  in_valid          in   1   in_data valid this cycle; no backpressure
//  in_data           in   8   message byte
//  in_sop            in   1   first byte of a message (qualified by in_valid)
//  in_eop            in   1   last byte of a message (qualified by in_valid)
//  order_id_out_add  out  16  order id, big-endian bytes 1-2
//  order_type_out_add out 1   1 = buy, 0 = sell
//  quantity_out_add  out  8   quantity, byte 4
//  price_out_add     out  16  price, big-endian bytes 5-6
//  add_valid         out  1   one-cycle strobe: fields above are a new order
//  parse_err         out  1   one-cycle strobe: malformed Add Order dropped
// BEHAVIOUR
//  Reset:
//  - All outputs 0; FSM to IDLE.
//  - Asserting rst_n low mid-message discards the partial message; no strobe is issued.
//  Add Order layout (7 bytes): [0] type | [1:2] id | [3] side | [4] qty | [5:6] price.
//  FSM: IDLE, ID_HI, ID_LO, SIDE, QTY, PR_HI, PR_LO, SKIP.
//  - Advances only on in_valid=1; in_valid=0 holds the state.
//  - IDLE: byte without sop is ignored.
//    - sop with ADD_TYPE -> ID_HI.
//    - sop with any other type -> SKIP, or stay IDLE if in_eop.
//  - ID_HI -> ID_LO -> SIDE -> QTY -> PR_HI -> PR_LO, capturing into shadow regs.
//    - SIDE byte must be BUY_CHAR or SELL_CHAR; otherwise error.
//  - PR_LO byte:
//    - with in_eop and no error: copy shadow regs to outputs; add_valid=1 next cycle; -> IDLE.
//    - without in_eop: error, -> SKIP.
//  - SKIP: wait for in_eop, then -> IDLE.
//  Errors:
//  - Early in_eop in ID_HI..PR_HI: parse_err next cycle, -> IDLE.
//  - Bad side byte: parse_err after message end; message discarded.
//  - sop while in ID_HI..PR_LO: current message aborted, parse_err=1.
//    - The sop byte is treated as a new type byte (IDLE rules, same cycle).
//  - sop while in SKIP: skipped message ends silently; new message starts.
//  - Single-byte ADD_TYPE message (sop+eop): parse_err.
//  Latency and output holding:
//  - 1 cycle from the accepted final byte to add_valid.
//  - Output fields change only with add_valid and hold otherwise; fields are never partially updated.
//  - add_valid and parse_err are never high together.
//  Throughput: back-to-back messages at 1 byte/cycle, no bubbles required.
// CONFIGURATION
//  PARSER_STATS_EN defined:
//  - Adds outputs msg_count[15:0] and err_count[15:0].
//  - msg_count: saturating count of add_valid pulses.
//  - err_count: saturating count of parse_err pulses.
//  - Both reset to 0 and stick at 16'hFFFF.
//  Undefined: these ports and their counters do not exist.
// TESTING
//  - Bytes 41 12 34 42 05 01 F4 (sop on 1st, eop on 7th) -> add_valid next cycle;
//    id=16'h1234, type=1, qty=8'h05, price=16'h01F4.
//  - Same message with side 53 and gaps of in_valid=0 between bytes -> one add_valid; type=0, fields correct.
//  - Msg 'E' (45 ..., 9 bytes) then Add 41 00 07 53 0A 00 64 back-to-back
//    -> only one add_valid; id=7, qty=10, price=100.
//  - Add message with eop on byte 4 -> parse_err=1 once; outputs keep previous values.
//  - sop+41 arriving at byte 3 of an Add -> parse_err for first;
//    second message completes with add_valid.
//  - rst_n low at byte 5 of an Add; remaining bytes fed -> no strobes;
//    outputs 0; next full message parses normally.

Source files
------------

// File: rtl/add_order_parser.sv
// Add Order byte-stream parser: decodes framed feed messages, strobes extracted fields.
// Optional PARSER_STATS_EN adds saturating msg_count/err_count outputs.
module add_order_parser #(
    parameter logic [7:0] ADD_TYPE  = 8'h41,
    parameter logic [7:0] BUY_CHAR  = 8'h42,
    parameter logic [7:0] SELL_CHAR = 8'h53
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic [15:0] order_id_out_add,
    output logic        order_type_out_add,
    output logic [7:0]  quantity_out_add,
    output logic [15:0] price_out_add,
    output logic        add_valid,
    output logic        parse_err
`ifdef PARSER_STATS_EN
    ,
    output logic [15:0] msg_count,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ID_HI = 3'd1,
        S_ID_LO = 3'd2,
        S_SIDE  = 3'd3,
        S_QTY   = 3'd4,
        S_PR_HI = 3'd5,
        S_PR_LO = 3'd6,
        S_SKIP  = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_add_fire;
    logic        w_err_fire;
    logic        w_in_body;
    logic [7:0]  r_id_hi;
    logic [7:0]  r_id_lo;
    logic        r_side_buy;
    logic        r_side_bad;
    logic [7:0]  r_qty;
    logic [7:0]  r_pr_hi;

    assign w_in_body = (r_state != S_IDLE) && (r_state != S_SKIP);

    // Next-state decode and strobe generation; a sop byte always restarts with IDLE rules.
    always_comb begin
        w_next_state = r_state;
        w_add_fire   = 1'b0;
        w_err_fire   = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                w_err_fire = w_in_body;
                if (in_data == ADD_TYPE) begin
                    if (in_eop) begin
                        w_err_fire   = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_ID_HI;
                    end
                end else if (in_eop) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_SKIP;
                end
            end else begin
                case (r_state)
                    S_IDLE: w_next_state = S_IDLE;
                    S_ID_HI, S_ID_LO, S_SIDE, S_QTY, S_PR_HI: begin
                        if (in_eop) begin
                            w_err_fire   = 1'b1;
                            w_next_state = S_IDLE;
                        end else begin
                            w_next_state = state_t'(r_state + 3'd1);
                        end
                    end
                    S_PR_LO: begin
                        if (in_eop) begin
                            w_add_fire   = ~r_side_bad;
                            w_err_fire   = r_side_bad;
                            w_next_state = S_IDLE;
                        end else begin
                            w_err_fire   = 1'b1;
                            w_next_state = S_SKIP;
                        end
                    end
                    S_SKIP: begin
                        if (in_eop) begin
                            w_next_state = S_IDLE;
                        end else begin
                            w_next_state = S_SKIP;
                        end
                    end
                    default: w_next_state = S_IDLE;
                endcase
            end
        end else begin
            w_next_state = r_state;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shadow capture of message body bytes; outputs only see them on a clean finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_hi    <= 8'h00;
            r_id_lo    <= 8'h00;
            r_side_buy <= 1'b0;
            r_side_bad <= 1'b0;
            r_qty      <= 8'h00;
            r_pr_hi    <= 8'h00;
        end else if (in_valid && in_sop) begin
            r_side_bad <= 1'b0;
        end else if (in_valid) begin
            case (r_state)
                S_ID_HI: r_id_hi <= in_data;
                S_ID_LO: r_id_lo <= in_data;
                S_SIDE: begin
                    r_side_buy <= (in_data == BUY_CHAR);
                    r_side_bad <= (in_data != BUY_CHAR) && (in_data != SELL_CHAR);
                end
                S_QTY:   r_qty   <= in_data;
                S_PR_HI: r_pr_hi <= in_data;
                default: r_pr_hi <= r_pr_hi;
            endcase
        end
    end

    // Registered strobes and atomic field update on a completed Add Order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_valid          <= 1'b0;
            parse_err          <= 1'b0;
            order_id_out_add   <= 16'h0000;
            order_type_out_add <= 1'b0;
            quantity_out_add   <= 8'h00;
            price_out_add      <= 16'h0000;
        end else begin
            add_valid <= w_add_fire;
            parse_err <= w_err_fire;
            if (w_add_fire) begin
                order_id_out_add   <= {r_id_hi, r_id_lo};
                order_type_out_add <= r_side_buy;
                quantity_out_add   <= r_qty;
                price_out_add      <= {r_pr_hi, in_data};
            end
        end
    end

`ifdef PARSER_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_count <= 16'h0000;
            err_count <= 16'h0000;
        end else begin
            if (add_valid && (msg_count != 16'hFFFF)) begin
                msg_count <= msg_count + 16'd1;
            end
            if (parse_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_add_order_parser.sv
// Self-checking bench for add_order_parser: directed vector table, hand sequences, random messages.
module tb_add_order_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [15:0] order_id_out_add;
    logic        order_type_out_add;
    logic [7:0]  quantity_out_add;
    logic [15:0] price_out_add;
    logic        add_valid;
    logic        parse_err;

    add_order_parser dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_sop            (in_sop),
        .in_eop            (in_eop),
        .order_id_out_add  (order_id_out_add),
        .order_type_out_add(order_type_out_add),
        .quantity_out_add  (quantity_out_add),
        .price_out_add     (price_out_add),
        .add_valid         (add_valid),
        .parse_err         (parse_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] b;
        int           len;
        logic [15:0]  sop_m;
        logic [15:0]  eop_m;
        bit           gap;
        int           exp_add;
        int           exp_err;
        logic [15:0]  exp_id;
        logic         exp_type;
        logic [7:0]   exp_qty;
        logic [15:0]  exp_price;
    } vec_t;

    typedef struct {
        bit          is_add;
        logic [15:0] id;
        logic        typ;
        logic [7:0]  qty;
        logic [15:0] price;
    } ev_t;

    int  checks = 0;
    int  errors = 0;
    int  n_add = 0;
    int  n_err = 0;
    bit  rec_on = 1'b0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    vec_t vecs[11];

    always @(negedge clk) begin
        if (add_valid || parse_err) begin
            checks++;
            if (add_valid && parse_err) begin
                errors++;
                $display("FAIL strobe_exclusive: add_valid=1 parse_err=1, required at most one high");
            end
        end
        if (add_valid) n_add++;
        if (parse_err) n_err++;
        if (rec_on && (add_valid || parse_err))
            obs_q.push_back('{add_valid, order_id_out_add, order_type_out_add,
                              quantity_out_add, price_out_add});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_fields(input string tag, input logic [15:0] id, input logic typ,
                                input logic [7:0] qty, input logic [15:0] price);
        check({tag, "_id"}, {16'h0, order_id_out_add}, {16'h0, id});
        check({tag, "_type"}, {31'h0, order_type_out_add}, {31'h0, typ});
        check({tag, "_qty"}, {24'h0, quantity_out_add}, {24'h0, qty});
        check({tag, "_price"}, {16'h0, price_out_add}, {16'h0, price});
    endtask

    task automatic send_msg(input logic [7:0] bytes[16], input int len, input bit gap);
        for (int j = 0; j < len; j++) begin
            drive_byte(bytes[j], (j == 0), (j == len - 1));
            if (gap && j < len - 1) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        int a0, e0;
        logic [7:0] mb[16];
        // Directed table: state carries from record to record, so field expectations include holds.
        vecs[0]  = '{{56'h41123442_0501F4, 72'h0}, 7, 16'h0001, 16'h0040, 1'b0, 1, 0, 16'h1234, 1'b1, 8'h05, 16'h01F4};
        vecs[1]  = '{{56'h41123453_0501F4, 72'h0}, 7, 16'h0001, 16'h0040, 1'b1, 1, 0, 16'h1234, 1'b0, 8'h05, 16'h01F4};
        vecs[2]  = '{{72'h45_0102030405060708, 56'h41000753_0A0064}, 16, 16'h0201, 16'h8100, 1'b0, 1, 0, 16'h0007, 1'b0, 8'h0A, 16'h0064};
        vecs[3]  = '{{32'h41AABB42, 96'h0}, 4, 16'h0001, 16'h0008, 1'b0, 0, 1, 16'h0007, 1'b0, 8'h0A, 16'h0064};
        vecs[4]  = '{{72'h4112_41ABCD42_7FFFFF, 56'h0}, 9, 16'h0005, 16'h0100, 1'b0, 1, 1, 16'hABCD, 1'b1, 8'h7F, 16'hFFFF};
        vecs[5]  = '{{8'h41, 120'h0}, 1, 16'h0001, 16'h0001, 1'b0, 0, 1, 16'hABCD, 1'b1, 8'h7F, 16'hFFFF};
        vecs[6]  = '{{56'h41010258_030405, 72'h0}, 7, 16'h0001, 16'h0040, 1'b0, 0, 1, 16'hABCD, 1'b1, 8'h7F, 16'hFFFF};
        vecs[7]  = '{{64'h41010242_03040506, 64'h0}, 8, 16'h0001, 16'h0080, 1'b0, 0, 1, 16'hABCD, 1'b1, 8'h7F, 16'hFFFF};
        vecs[8]  = '{{8'h58, 120'h0}, 1, 16'h0001, 16'h0001, 1'b0, 0, 0, 16'hABCD, 1'b1, 8'h7F, 16'hFFFF};
        vecs[9]  = '{{24'h414242, 104'h0}, 3, 16'h0000, 16'h0004, 1'b0, 0, 0, 16'hABCD, 1'b1, 8'h7F, 16'hFFFF};
        vecs[10] = '{{56'h41FFFF42_FFFFFF, 72'h0}, 7, 16'h0001, 16'h0040, 1'b1, 1, 0, 16'hFFFF, 1'b1, 8'hFF, 16'hFFFF};

        idle(2);
        check("reset_add_valid", {31'h0, add_valid}, 32'h0);
        check("reset_parse_err", {31'h0, parse_err}, 32'h0);
        check_fields("reset", 16'h0000, 1'b0, 8'h00, 16'h0000);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 11; i++) begin
            a0 = n_add;
            e0 = n_err;
            for (int j = 0; j < vecs[i].len; j++) begin
                drive_byte(vecs[i].b[127 - 8*j -: 8], vecs[i].sop_m[j], vecs[i].eop_m[j]);
                if (vecs[i].gap && j < vecs[i].len - 1) idle($urandom_range(1, 2));
            end
            idle(2);
            check($sformatf("vec%0d_adds", i), n_add - a0, vecs[i].exp_add);
            check($sformatf("vec%0d_errs", i), n_err - e0, vecs[i].exp_err);
            check_fields($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_type,
                         vecs[i].exp_qty, vecs[i].exp_price);
        end

        // Reset asserted while byte 5 of an Add is on the bus; tail bytes must be ignored.
        a0 = n_add;
        e0 = n_err;
        drive_byte(8'h41, 1'b1, 1'b0);
        drive_byte(8'h12, 1'b0, 1'b0);
        drive_byte(8'h34, 1'b0, 1'b0);
        drive_byte(8'h42, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive_byte(8'h05, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive_byte(8'h01, 1'b0, 1'b0);
        drive_byte(8'hF4, 1'b0, 1'b1);
        idle(2);
        check("rst_mid_adds", n_add - a0, 0);
        check("rst_mid_errs", n_err - e0, 0);
        check_fields("rst_mid", 16'h0000, 1'b0, 8'h00, 16'h0000);
        a0 = n_add;
        mb = '{8'h41, 8'h0F, 8'h0E, 8'h53, 8'h0D, 8'h0C, 8'h0B, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        send_msg(mb, 7, 1'b0);
        idle(2);
        check("post_rst_adds", n_add - a0, 1);
        check_fields("post_rst", 16'h0F0E, 1'b0, 8'h0D, 16'h0C0B);

        // Random framed messages against a message-level outcome model.
        rec_on = 1'b1;
        for (int m = 0; m < 150; m++) begin
            int len;
            logic [7:0] t;
            bit is_add_type;
            is_add_type = ($urandom_range(0, 1) == 1);
            if (is_add_type) begin
                t = 8'h41;
                len = ($urandom_range(0, 9) < 7) ? 7 : $urandom_range(1, 10);
            end else begin
                t = 8'($urandom_range(0, 255));
                while (t == 8'h41) t = 8'($urandom_range(0, 255));
                len = $urandom_range(1, 10);
            end
            for (int j = 0; j < 16; j++) mb[j] = 8'($urandom_range(0, 255));
            mb[0] = t;
            case ($urandom_range(0, 2))
                0: mb[3] = 8'h42;
                1: mb[3] = 8'h53;
                default: mb[3] = mb[3];
            endcase
            if (is_add_type) begin
                if (len == 7 && (mb[3] == 8'h42 || mb[3] == 8'h53))
                    exp_q.push_back('{1'b1, {mb[1], mb[2]}, (mb[3] == 8'h42), mb[4], {mb[5], mb[6]}});
                else
                    exp_q.push_back('{1'b0, 16'h0, 1'b0, 8'h0, 16'h0});
            end
            for (int j = 0; j < len; j++) begin
                drive_byte(mb[j], (j == 0), (j == len - 1));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(3);
        rec_on = 1'b0;
        check("rand_event_count", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check($sformatf("rand%0d_kind", k), {31'h0, obs_q[k].is_add}, {31'h0, exp_q[k].is_add});
            if (exp_q[k].is_add && obs_q[k].is_add) begin
                check($sformatf("rand%0d_fields", k),
                      {obs_q[k].id, obs_q[k].qty, 7'h0, obs_q[k].typ},
                      {exp_q[k].id, exp_q[k].qty, 7'h0, exp_q[k].typ});
                check($sformatf("rand%0d_price", k), {16'h0, obs_q[k].price}, {16'h0, exp_q[k].price});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
